// File: rtl/team4_cpu.sv
// rtl/team4_cpu.sv - 16-bit register CPU with a UART-style instruction load port
//
// Purpose: a host streams instruction words into IMEM through the load port,
// then sends an operand that starts a run from PC 0. The CPU executes one
// instruction per clock until HALT (or until the step watchdog expires), then
// pulses done with the result on DataOut.
//
// Ports:
//   clk        in   1   clock, all state on rising edge
//   reset      in   1   synchronous, active-high reset
//   uart_en    in   1   strobe: uart_sel/uart_data valid (sampled in IDLE only)
//   uart_sel   in   2   0 none, 1 load instr, 2 operand+start, 3 rewind load pointer
//   uart_data  in   16  instruction word or operand
//   DataOut    out  16  value of R[rd] at the last HALT
//   done       out  1   one-cycle pulse at end of run
module team4_cpu #(
  parameter int IMEM_DEPTH = 32,
  parameter int DMEM_DEPTH = 16,
  parameter int MAX_STEPS  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_en,
  input  logic [1:0]  uart_sel,
  input  logic [15:0] uart_data,
  output logic [15:0] DataOut,
  output logic        done
);

  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);
  localparam int SW = $clog2(MAX_STEPS + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(MAX_STEPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [15:0]   imem [IMEM_DEPTH];
  logic [15:0]   dmem [DMEM_DEPTH];
  logic [15:0]   regs [8];
  logic [IW-1:0] pc, wptr, pc_next;
  logic [SW-1:0] steps;
  logic [15:0]   inreg;

  logic [15:0]   instr, sext6, rs_val, rt_val, rd_val, wb_val;
  logic [3:0]    op;
  logic [2:0]    rd, rs, rt;
  logic [DW-1:0] daddr;
  logic          running, wb_en, st_en, halt, wd_expire;

  // Decode and execute the instruction at PC combinationally; results are
  // committed at the end of the cycle so the next instruction sees them.
  always_comb begin
    instr   = imem[pc];
    op      = instr[15:12];
    rd      = instr[11:9];
    rs      = instr[8:6];
    rt      = instr[5:3];
    sext6   = {{10{instr[5]}}, instr[5:0]};
    rd_val  = regs[rd];
    rs_val  = regs[rs];
    rt_val  = regs[rt];
    daddr   = DW'(rs_val + sext6);
    running = (state_q == RUN);
    wb_en   = 1'b0;
    st_en   = 1'b0;
    wb_val  = 16'h0000;
    pc_next = pc + IW'(1);
    case (op)
      4'h1: begin wb_en = 1'b1; wb_val = rs_val + rt_val; end
      4'h2: begin wb_en = 1'b1; wb_val = rs_val - rt_val; end
      4'h3: begin wb_en = 1'b1; wb_val = rs_val & rt_val; end
      4'h4: begin wb_en = 1'b1; wb_val = rs_val | rt_val; end
      4'h5: begin wb_en = 1'b1; wb_val = rs_val ^ rt_val; end
      4'h6: begin wb_en = 1'b1; wb_val = rs_val << instr[3:0]; end
      4'h7: begin wb_en = 1'b1; wb_val = rs_val >> instr[3:0]; end
      4'h8: begin wb_en = 1'b1; wb_val = rs_val + sext6; end
      4'h9: begin wb_en = 1'b1; wb_val = {7'd0, instr[8:0]}; end
      4'hA: begin wb_en = 1'b1; wb_val = dmem[daddr]; end
      4'hB: st_en = 1'b1;
      4'hC: if (rd_val == rs_val) pc_next = pc + IW'(1) + sext6[IW-1:0];
      4'hD: pc_next = instr[IW-1:0];
      4'hE: begin wb_en = 1'b1; wb_val = inreg; end
      default: ;
    endcase
    halt      = running && (op == 4'h0);
    // The MAX_STEPS-th instruction still executes; the run ends with it.
    wd_expire = running && !halt && (steps == STEP_LAST);

    state_d = state_q;
    case (state_q)
      IDLE: if (uart_en && uart_sel == 2'd2) state_d = RUN;
      RUN:  if (halt || wd_expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc      <= '0;
      wptr    <= '0;
      steps   <= '0;
      inreg   <= 16'h0000;
      DataOut <= 16'h0000;
      done    <= 1'b0;
      for (int i = 0; i < IMEM_DEPTH; i++) imem[i] <= 16'h0000;
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= 16'h0000;
      for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (state_q == IDLE) begin
        if (uart_en) begin
          case (uart_sel)
            2'd1: begin imem[wptr] <= uart_data; wptr <= wptr + IW'(1); end
            2'd2: begin inreg <= uart_data; pc <= '0; steps <= '0; end
            2'd3: wptr <= '0;
            default: ;
          endcase
        end
      end else begin
        pc    <= pc_next;
        steps <= steps + SW'(1);
        if (wb_en) regs[rd] <= wb_val;
        if (st_en) dmem[daddr] <= rd_val;
        if (halt) DataOut <= rd_val;
        if (halt || wd_expire) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_team4_cpu.sv
// tb/tb_team4_cpu.sv - scoreboard testbench for team4_cpu
module tb_team4_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_en = 1'b0;
  logic [1:0]  uart_sel = 2'd0;
  logic [15:0] uart_data = 16'h0000;
  logic [15:0] DataOut;
  logic        done;

  team4_cpu dut (
    .clk(clk), .reset(reset), .uart_en(uart_en), .uart_sel(uart_sel),
    .uart_data(uart_data), .DataOut(DataOut), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   spurious = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected run result.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (q.size() == 0) begin
        spurious++;
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("dataout", {16'd0, DataOut}, {16'd0, e.data});
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [15:0] d);
    uart_en = 1'b1; uart_sel = s; uart_data = d;
    tick();
    uart_en = 1'b0; uart_sel = 2'd0; uart_data = 16'h0000;
  endtask

  task automatic load(input logic [15:0] w[$]);
    send(2'd3, 16'h0000);
    foreach (w[i]) send(2'd1, w[i]);
  endtask

  // cyc right after send() is the edge that sampled the start strobe.
  task automatic start(input logic [15:0] d, input logic [15:0] exp, input int lat);
    send(2'd2, d);
    q.push_back('{exp, cyc + lat});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && q.size() != 0; i++) tick();
    check("run_timeout", q.size(), 32'd0);
    q.delete();
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_dataout", {16'd0, DataOut}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);

    // IN R1; ADD R2,R2,R1; HALT R2 -- R2 accumulates across runs
    load('{16'hE200, 16'h1488, 16'h0400});
    start(16'd100, 16'd100, 3); wait_idle();
    start(16'd200, 16'd300, 3); wait_idle();
    start(16'd300, 16'd600, 3); wait_idle();

    // rewind: LDI R1,20; HALT R1
    load('{16'h9214, 16'h0200});
    start(16'd0, 16'h0014, 2); wait_idle();

    // LDI R3,0x123; LDI R4,5; ST R3,[R4-2]; LD R5,[R0+3]; HALT R5
    load('{16'h9723, 16'h9805, 16'hB73E, 16'hAA03, 16'h0A00});
    start(16'd0, 16'h0123, 5); wait_idle();

    // counting loop: BEQ not-taken/taken and a negative-offset back branch
    load('{16'h9200, 16'h9403, 16'h8241, 16'hC281, 16'hC03D, 16'h0200});
    start(16'd0, 16'd3, 11); wait_idle();

    // ALU chain: SHL, SHR, XOR, SUB, AND, OR
    load('{16'h92F3, 16'h6444, 16'h7688, 16'h5898, 16'h2AD0, 16'h3D60, 16'h4F90, 16'h0E00});
    start(16'd0, 16'h0F3F, 8); wait_idle();

    // JMP 0 forever: watchdog ends the run, DataOut keeps last HALT value.
    // Load-port writes during the run must be ignored (else IMEM[0] becomes HALT).
    load('{16'hD000});
    start(16'd0, 16'h0F3F, 255);
    repeat (5) tick();
    send(2'd3, 16'h0000);
    send(2'd1, 16'h0E00);
    wait_idle();
    start(16'd0, 16'h0F3F, 255); wait_idle();

    // reset mid-run: no done pulse, everything cleared
    send(2'd2, 16'h0000);
    repeat (20) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrun_reset_dataout", {16'd0, DataOut}, 32'd0);
    check("midrun_reset_done", {31'd0, done}, 32'd0);
    repeat (300) tick();
    check("no_done_after_reset", spurious, 32'd0);

    // IMEM cleared to HALT R0, R0 cleared
    start(16'h1234, 16'h0000, 1); wait_idle();

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
